// File: rtl/ahbl_aphase_arbiter.sv
// AHB-Lite address-phase arbiter for N masters feeding one slave-side port.
// Each master has a one-entry cache that holds an address phase the slave
// has not yet taken. Arbitration is round-robin or fixed priority. A grant
// issued while the slave stalls is locked until the slave accepts it.
module ahbl_aphase_arbiter #(
  parameter int N_MASTERS  = 2,
  parameter int APHASE_W   = 46,
  parameter int HTRANS_LSB = 1,
  parameter int RR_MODE    = 1,
  localparam int IDW       = $clog2(N_MASTERS)
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic [N_MASTERS*APHASE_W-1:0] m_aphase_in,
  output logic [N_MASTERS-1:0]          m_hready_out,
  output logic [APHASE_W-1:0]           s_aphase_out,
  input  logic                          s_hready_in,
  output logic [IDW-1:0]                grant_id,
  output logic                          grant_valid,
  output logic [IDW-1:0]                dphase_id,
  output logic                          dphase_valid
);

  // Registered state
  logic [N_MASTERS-1:0] valid_q, valid_d;
  logic [APHASE_W-1:0]  cache_q [N_MASTERS];
  logic [APHASE_W-1:0]  cache_d [N_MASTERS];
  logic                 lock_q, lock_d;
  logic [IDW-1:0]       lock_id_q, lock_id_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]       dphase_id_q, dphase_id_d;
  logic                 dphase_valid_q, dphase_valid_d;

  // Per-master views of the incoming phases
  logic [APHASE_W-1:0]  slice [N_MASTERS];
  logic [APHASE_W-1:0]  eff   [N_MASTERS];
  logic [N_MASTERS-1:0] active;
  logic [N_MASTERS-1:0] pend;
  logic                 acc;

  // Split the master bus, detect non-IDLE transfers, pick live or cached phase.
  always_comb begin
    for (int i = 0; i < N_MASTERS; i++) begin
      slice[i]  = m_aphase_in[i*APHASE_W +: APHASE_W];
      active[i] = (slice[i][HTRANS_LSB +: 2] != 2'b00);
      pend[i]   = valid_q[i] | active[i];
      eff[i]    = valid_q[i] ? cache_q[i] : slice[i];
    end
  end

  // Arbitration: a locked (stalled) grant wins, otherwise RR or fixed priority.
  always_comb begin
    int  idx;
    logic found;
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    grant_id = '0;
    idx      = 0;
    found    = 1'b0;
    if (lock_q) begin
      grant_id = lock_id_q;
    end else if (RR_MODE != 0) begin
      for (int k = 1; k <= N_MASTERS; k++) begin
        idx = (int'(rr_ptr_q) + k) % N_MASTERS;
        if (!found && pend[idx]) begin
          grant_id = IDW'(idx);
          found    = 1'b1;
        end
      end
    end else begin
      for (int i = N_MASTERS - 1; i >= 0; i--) begin
        if (pend[i]) grant_id = IDW'(i);
      end
    end
    grant_valid  = lock_q | (|pend);
    s_aphase_out = grant_valid ? eff[grant_id] : '0;
  end

  assign acc = grant_valid & s_hready_in;

  // Next state: accept, idle-slave retire, stall lock and per-master capture.
  always_comb begin
    valid_d        = valid_q;
    cache_d        = cache_q;
    lock_d         = lock_q;
    lock_id_d      = lock_id_q;
    rr_ptr_d       = rr_ptr_q;
    dphase_id_d    = dphase_id_q;
    dphase_valid_d = dphase_valid_q;

    if (acc) begin
      dphase_id_d    = grant_id;
      dphase_valid_d = 1'b1;
      rr_ptr_d       = grant_id;
      lock_d         = 1'b0;
    end else if (s_hready_in) begin
      // Slave ready with nothing to take: the data phase simply ends.
      dphase_valid_d = 1'b0;
    end else if (grant_valid) begin
      // Slave stalling: freeze this grant until it is taken.
      lock_d    = 1'b1;
      lock_id_d = grant_id;
    end

    for (int i = 0; i < N_MASTERS; i++) begin
      if (acc && grant_id == IDW'(i)) begin
        valid_d[i] = 1'b0;
        cache_d[i] = '0;
      end else if (active[i] && !valid_q[i]) begin
        valid_d[i] = 1'b1;
        cache_d[i] = slice[i];
      end
    end
  end

  // State register with synchronous reset; pending phases are dropped on reset.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      valid_q        <= '0;
      // NOTE: the phase cache is a handful of flops, not a RAM, and must read back as zero after reset, so it is cleared here.
      cache_q        <= '{default: '0};
      lock_q         <= 1'b0;
      lock_id_q      <= '0;
      rr_ptr_q       <= IDW'(N_MASTERS - 1);
      dphase_id_q    <= '0;
      dphase_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values computed above.
      valid_q        <= valid_d;
      cache_q        <= cache_d;
      lock_q         <= lock_d;
      lock_id_q      <= lock_id_d;
      rr_ptr_q       <= rr_ptr_d;
      dphase_id_q    <= dphase_id_d;
      dphase_valid_q <= dphase_valid_d;
    end
  end

  // HREADY back to each master: data-phase owner follows the slave, a master
  // with a waiting cached phase is stalled, everyone else sees ready.
  always_comb begin
    for (int i = 0; i < N_MASTERS; i++) begin
      if (dphase_valid_q && dphase_id_q == IDW'(i)) m_hready_out[i] = s_hready_in;
      else if (valid_q[i])                          m_hready_out[i] = 1'b0;
      else                                          m_hready_out[i] = 1'b1;
    end
  end

  assign dphase_id    = dphase_id_q;
  assign dphase_valid = dphase_valid_q;

endmodule

// File: tb/tb_ahbl_aphase_arbiter.sv
// Directed bench for ahbl_aphase_arbiter: a vector table for the 2-master
// round-robin instance plus hand sequences for reset and 3-master fairness.
module tb_ahbl_aphase_arbiter;

  localparam int AW = 46;
  localparam logic [1:0] ID = 2'b00;
  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] SQ = 2'b11;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  // 2-master round-robin instance
  logic [2*AW-1:0] m_aphase_in;
  logic [1:0]      m_hready_out;
  logic [AW-1:0]   s_aphase_out;
  logic            s_hready_in;
  logic            grant_id, grant_valid, dphase_id, dphase_valid;

  ahbl_aphase_arbiter #(.N_MASTERS(2), .APHASE_W(AW), .HTRANS_LSB(1), .RR_MODE(1)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .m_aphase_in(m_aphase_in), .m_hready_out(m_hready_out),
    .s_aphase_out(s_aphase_out), .s_hready_in(s_hready_in), .grant_id(grant_id),
    .grant_valid(grant_valid), .dphase_id(dphase_id), .dphase_valid(dphase_valid)
  );

  // 3-master instances, round-robin and fixed priority, shared stimulus
  logic [3*AW-1:0] m3_aphase;
  logic [2:0]      hr3r, hr3f;
  logic [AW-1:0]   sa3r, sa3f;
  logic [1:0]      gid3r, gid3f, did3r, did3f;
  logic            gv3r, gv3f, dv3r, dv3f;

  ahbl_aphase_arbiter #(.N_MASTERS(3), .APHASE_W(AW), .HTRANS_LSB(1), .RR_MODE(1)) dut3r (
    .HCLK(HCLK), .HRESET(HRESET), .m_aphase_in(m3_aphase), .m_hready_out(hr3r),
    .s_aphase_out(sa3r), .s_hready_in(1'b1), .grant_id(gid3r),
    .grant_valid(gv3r), .dphase_id(did3r), .dphase_valid(dv3r)
  );

  ahbl_aphase_arbiter #(.N_MASTERS(3), .APHASE_W(AW), .HTRANS_LSB(1), .RR_MODE(0)) dut3f (
    .HCLK(HCLK), .HRESET(HRESET), .m_aphase_in(m3_aphase), .m_hready_out(hr3f),
    .s_aphase_out(sa3f), .s_hready_in(1'b1), .grant_id(gid3f),
    .grant_valid(gv3f), .dphase_id(did3f), .dphase_valid(dv3f)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [AW-1:0] ph(input logic [42:0] a, input logic [1:0] t);
    return {a, t, 1'b0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [1:0] t0, input logic [42:0] a0,
                       input logic [1:0] t1, input logic [42:0] a1, input logic rdy);
    HRESET      = rst;
    m_aphase_in = {ph(a1, t1), ph(a0, t0)};
    s_hready_in = rdy;
  endtask

  task automatic next_cycle();
    @(posedge HCLK);
    #1;
  endtask

  typedef struct packed {
    logic        rst;
    logic [1:0]  t0;
    logic [42:0] a0;
    logic [1:0]  t1;
    logic [42:0] a1;
    logic        rdy;
    logic        chk;
    logic [1:0]  e_hrdy;
    logic [AW-1:0] e_aph;
    logic        e_gv;
    logic        e_gid;
    logic        e_dpv;
    logic        e_dpid;
  } vec_t;

  function automatic vec_t mkv(input logic rst, input logic [1:0] t0, input logic [42:0] a0,
                               input logic [1:0] t1, input logic [42:0] a1, input logic rdy,
                               input logic chk, input logic [1:0] e_hrdy, input logic [AW-1:0] e_aph,
                               input logic e_gv, input logic e_gid, input logic e_dpv,
                               input logic e_dpid);
    vec_t v;
    v = '{rst: rst, t0: t0, a0: a0, t1: t1, a1: a1, rdy: rdy, chk: chk, e_hrdy: e_hrdy,
          e_aph: e_aph, e_gv: e_gv, e_gid: e_gid, e_dpv: e_dpv, e_dpid: e_dpid};
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    // rst t0 a0 t1 a1 rdy chk | hrdy aph gv gid dpv dpid
    vecs.push_back(mkv(0, ID, 0,      ID, 0,      1, 1, 2'b11, '0,             0, 0, 0, 0)); // reset state
    vecs.push_back(mkv(0, NS, 'h100,  ID, 0,      1, 1, 2'b11, ph('h100, NS),  1, 0, 0, 0)); // single master
    vecs.push_back(mkv(0, ID, 0,      ID, 0,      0, 1, 2'b10, '0,             0, 0, 1, 0)); // m0 dphase, slave waits
    vecs.push_back(mkv(0, ID, 0,      ID, 0,      1, 1, 2'b11, '0,             0, 0, 1, 0)); // m0 dphase done
    vecs.push_back(mkv(1, ID, 0,      ID, 0,      1, 0, 2'b11, '0,             0, 0, 0, 0)); // reset
    vecs.push_back(mkv(0, NS, 'h200,  NS, 'h300,  1, 1, 2'b11, ph('h200, NS),  1, 0, 0, 0)); // contention c0
    vecs.push_back(mkv(0, ID, 0,      SQ, 'h304,  1, 1, 2'b01, ph('h300, NS),  1, 1, 1, 0)); // c1: cache[1] out
    vecs.push_back(mkv(0, ID, 0,      ID, 0,      1, 1, 2'b11, '0,             0, 0, 1, 1)); // c2: m1 released
    vecs.push_back(mkv(0, ID, 0,      NS, 'h400,  0, 1, 2'b11, ph('h400, NS),  1, 1, 0, 0)); // stall 1
    vecs.push_back(mkv(0, NS, 'h500,  NS, 'h400,  0, 1, 2'b01, ph('h400, NS),  1, 1, 0, 0)); // stall 2, m0 captured
    vecs.push_back(mkv(0, SQ, 'h504,  NS, 'h400,  0, 1, 2'b00, ph('h400, NS),  1, 1, 0, 0)); // stall 3
    vecs.push_back(mkv(0, SQ, 'h504,  NS, 'h400,  1, 1, 2'b00, ph('h400, NS),  1, 1, 0, 0)); // accept
    vecs.push_back(mkv(0, SQ, 'h504,  ID, 0,      1, 1, 2'b10, ph('h500, NS),  1, 0, 1, 1)); // m0 from cache
    vecs.push_back(mkv(0, NS, 'h600,  ID, 0,      0, 1, 2'b10, ph('h600, NS),  1, 0, 1, 0)); // owner regranted, stall
    vecs.push_back(mkv(0, NS, 'h600,  ID, 0,      1, 1, 2'b11, ph('h600, NS),  1, 0, 1, 0)); // owner follows slave
    vecs.push_back(mkv(0, ID, 0,      ID, 0,      1, 1, 2'b11, '0,             0, 0, 1, 0)); // idle c0
    vecs.push_back(mkv(0, ID, 0,      ID, 0,      1, 1, 2'b11, '0,             0, 0, 0, 0)); // idle c1

    m3_aphase = '0;
    drive(1, ID, 0, ID, 0, 1);
    repeat (2) @(posedge HCLK);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].t0, vecs[i].a0, vecs[i].t1, vecs[i].a1, vecs[i].rdy);
      #1;
      if (vecs[i].chk) begin
        check($sformatf("v%0d m_hready_out", i), 64'(m_hready_out), 64'(vecs[i].e_hrdy));
        check($sformatf("v%0d s_aphase_out", i), 64'(s_aphase_out), 64'(vecs[i].e_aph));
        check($sformatf("v%0d grant_valid", i), 64'(grant_valid), 64'(vecs[i].e_gv));
        if (vecs[i].e_gv) check($sformatf("v%0d grant_id", i), 64'(grant_id), 64'(vecs[i].e_gid));
        check($sformatf("v%0d dphase_valid", i), 64'(dphase_valid), 64'(vecs[i].e_dpv));
        if (vecs[i].e_dpv) check($sformatf("v%0d dphase_id", i), 64'(dphase_id), 64'(vecs[i].e_dpid));
      end
      next_cycle();
    end

    // Reset mid-operation: build valid[1]=1 with m0 owning the data phase.
    drive(0, ID, 0, NS, 'h800, 1);
    #1;
    check("rst_a grant_id", 64'(grant_id), 64'd1);
    next_cycle();
    drive(0, NS, 'h700, NS, 'h810, 1);
    #1;
    check("rst_b grant_id", 64'(grant_id), 64'd0);
    next_cycle();
    drive(1, ID, 0, ID, 0, 1);
    #1;
    check("rst_c pre m_hready_out", 64'(m_hready_out), 64'b01);
    check("rst_c pre dphase_valid", 64'(dphase_valid), 64'd1);
    next_cycle();
    drive(0, ID, 0, ID, 0, 1);
    #1;
    check("rst_d m_hready_out", 64'(m_hready_out), 64'b11);
    check("rst_d s_aphase_out", 64'(s_aphase_out), 64'd0);
    check("rst_d grant_valid", 64'(grant_valid), 64'd0);
    check("rst_d dphase_valid", 64'(dphase_valid), 64'd0);
    next_cycle();
    drive(0, NS, 'h900, NS, 'h910, 1);
    #1;
    check("rst_e grant_id", 64'(grant_id), 64'd0);
    check("rst_e s_aphase_out", 64'(s_aphase_out), 64'(ph('h900, NS)));
    next_cycle();

    // Fairness with three masters requesting every cycle.
    drive(1, ID, 0, ID, 0, 1);
    next_cycle();
    HRESET = 1'b0;
    for (int m = 0; m < 3; m++) m3_aphase[m*AW +: AW] = ph(43'('h1000 + m), NS);
    for (int c = 0; c < 6; c++) begin
      #1;
      check($sformatf("rr c%0d grant_id", c), 64'(gid3r), 64'(c % 3));
      check($sformatf("rr c%0d s_aphase_out", c), 64'(sa3r), 64'(ph(43'('h1000 + (c % 3)), NS)));
      check($sformatf("fp c%0d grant_id", c), 64'(gid3f), 64'd0);
      check($sformatf("fp c%0d grant_valid", c), 64'(gv3f), 64'd1);
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahbl_aphase_arbiter.md
Name: ahbl_aphase_arbiter

Overview:
- N-master AHB-Lite address-phase arbiter with per-master address-phase caching, placed between the master ports and one downstream slave/decoder port of the bus mux.
- Each master has a one-entry cache that captures its address phase when the master is not granted, or when it is granted while the slave is stalling.
- Masters whose captured phase is waiting are stalled via their own HREADY.
- Adds fixed-priority or round-robin arbitration, data-phase owner tracking and parametrised width/channel count.

Parameters:
- N_MASTERS, 2: number of upstream masters (>=2).
- APHASE_W, 46: width of one address-phase bundle.
- HTRANS_LSB, 1: bit position of the 2-bit HTRANS field inside a bundle.
- RR_MODE, 1: arbitration mode. 1 = round-robin, 0 = fixed priority (master 0 highest).
- IDW (localparam): $clog2(N_MASTERS).

Ports:
- HCLK  in  1  bus clock; all state updates on the rising edge.
- HRESET  in  1  synchronous active-high reset.
- m_aphase_in  in  N_MASTERS*APHASE_W  master address phases; master i occupies [i*APHASE_W +: APHASE_W].
- m_hready_out  out  N_MASTERS  HREADY returned to each master.
- s_aphase_out  out  APHASE_W  address phase driven to the slave side.
- s_hready_in  in  1  HREADY from the slave side.
- grant_id  out  IDW  master whose address phase is currently on s_aphase_out.
- grant_valid  out  1  some master is presenting a phase on s_aphase_out.
- dphase_id  out  IDW  owner of the current data phase.
- dphase_valid  out  1  a data phase is in progress.

Behaviour:
- Pending condition: pend[i] = valid[i] OR (HTRANS of m_aphase_in slice i != IDLE 2'b00).
- Effective phase: eff[i] = valid[i] ? cache[i] : m_aphase_in slice i.
- Arbitration (combinational, per cycle):
  - If lock=1, pick lock_id.
  - Else with RR_MODE=1: first pending index searching upward from rr_ptr+1, wrapping modulo N_MASTERS.
  - Else with RR_MODE=0: lowest pending index.
  - grant_valid = any pend or lock.
  - s_aphase_out = eff[grant_id] when grant_valid; otherwise all zeros (IDLE).
- Accept: acc = grant_valid AND s_hready_in. On acc:
  - dphase_id <= grant_id, dphase_valid <= 1.
  - rr_ptr <= grant_id.
  - valid[grant_id] <= 0, cache[grant_id] <= 0.
  - lock <= 0.
- Idle slave: s_hready_in=1 AND !grant_valid -> dphase_valid <= 0.
- Stall hold: grant_valid AND !s_hready_in -> lock <= 1, lock_id <= grant_id. The grant and s_aphase_out must not change until s_hready_in=1. dphase_id/dphase_valid hold.
- Cache capture, per master i, when not (acc AND grant_id==i):
  - If HTRANS(slice i) != IDLE and valid[i]=0: valid[i] <= 1, cache[i] <= slice i.
  - Otherwise valid[i]/cache[i] hold.
  - A cached phase is never overwritten until it is accepted.
- m_hready_out[i]:
  - = s_hready_in if dphase_valid AND dphase_id==i.
  - else 0 if valid[i].
  - else 1.
- Simultaneous events:
  - Master accepted in the same cycle it presents a new phase: no capture; the phase goes straight downstream.
  - Data-phase owner also granted the next address phase: its m_hready_out follows s_hready_in. The pipelined phase is cached if the slave stalls.
- Reset (HRESET=1 at an edge):
  - valid=0, cache=0, lock=0, lock_id=0.
  - dphase_valid=0, dphase_id=0.
  - rr_ptr=N_MASTERS-1, so master 0 wins first.
- Outputs immediately after reset, with all masters IDLE: m_hready_out=all 1s, s_aphase_out=0, grant_valid=0.
- Reset mid-transfer: all cached phases are discarded with no replay.

Test Plan:
- Single master: N=2, master 0 NONSEQ addr 0x100, s_hready_in=1 -> same cycle s_aphase_out=slice0, grant_id=0; next cycle dphase_id=0, dphase_valid=1, m_hready_out[0] follows s_hready_in.
- Contention, RR_MODE=1: masters 0 and 1 both NONSEQ in cycle 0.
  - Cycle 0: master 0 granted, master 1 cached, m_hready_out[1]=1.
  - Cycle 1: m_hready_out[1]=0, s_aphase_out=cache[1], grant_id=1.
  - Cycle 2: valid[1]=0, m_hready_out[1]=1.
- Slave stall: grant master 1 with s_hready_in=0 for 3 cycles.
  - grant_id=1 and s_aphase_out held constant for all 3 cycles.
  - Master 0 NONSEQ is captured, not granted.
  - Accept on cycle 4, then master 0 granted.
- Fairness: 3 masters continuously NONSEQ, RR_MODE=1 -> grant sequence 0,1,2,0,1,2. Same stimulus with RR_MODE=0 -> a master that is re-requesting each time stays granted: 0,0,0.
- Reset mid-operation: assert HRESET with valid[1]=1 and dphase_valid=1 -> next cycle valid=0, dphase_valid=0, m_hready_out=all 1s, s_aphase_out=0; master 0 wins first after reset.
- Idle: all HTRANS=IDLE with s_hready_in=1 -> s_aphase_out=0, grant_valid=0; dphase_valid falls to 0 one cycle later.
